aes_sbox_scheduler: RTL
=======================

# aes_sbox_scheduler

Shared S-box resource controller for the iterative AES core. Time-multiplexes four `aes_sbox` instances between two requesters:
- the round datapath, which needs SubBytes on a 128-bit state;
- the key expansion, which needs the g-function on a 32-bit word: optional RotWord, then SubWord, then Rcon XOR.

Arbitration, sequencing and result capture live here, so the core instantiates 4 S-boxes instead of 20.

## Interface
Parameters:
- `RR_EN`, default 1: 1 = round-robin arbitration between requesters; 0 = key requester has fixed priority.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `st_valid`  in  1  state SubBytes request.
- `st_ready`  out  1  state request accepted when `st_valid & st_ready` at a rising edge.
- `st_data`  in  128  state to substitute; byte k = bits [8k+7:8k].
- `st_out_valid`  out  1  one-cycle pulse, `st_out` valid.
- `st_out`  out  128  substituted state, same byte mapping.
- `ks_valid`  in  1  key-word request.
- `ks_ready`  out  1  key request accepted when `ks_valid & ks_ready`.
- `ks_word`  in  32  input word; byte 3 = [31:24] is the first AES byte.
- `ks_rot`  in  1  apply RotWord before SubWord.
- `ks_rcon`  in  8  XORed into result bits [31:24] after SubWord; 0 means no Rcon.
- `ks_out_valid`  out  1  one-cycle pulse.
- `ks_out`  out  32  g-function result.
- `busy`  out  1  FSM not in IDLE.

## Operation
- Four combinational `aes_sbox` instances. Their 32-bit input is muxed from the captured state group or the captured key word.
- FSM states: IDLE, ST0, ST1, ST2, ST3, KS.
- `st_ready` = `ks_ready` = 0 outside IDLE. In IDLE, readiness follows arbitration:
  - Only one valid: that requester is ready.
  - Both valid, `RR_EN`=1: grant the requester not granted last. `last_grant` resets to KEY, so the first contention goes to state.
  - Both valid, `RR_EN`=0: key wins; `st_ready`=0.
  - Neither valid: both readies are 1.
  - Ready never depends on the other requester's acceptance in the same cycle, except through the contention rule above.
- Accepting a state request captures `st_data` into a 128-bit register and moves to ST0.
- In STi the S-boxes take state bits [32i+31:32i]. The result is written into the same 32-bit lane of the output register at the end of STi.
  - ST0 → ST1 → ST2 → ST3 → IDLE unconditionally.
- Accepting a key request captures the key word, pre-rotated if `ks_rot` ({w[23:0], w[31:24]}), plus `ks_rcon`, and moves to KS.
  - In KS, SubWord is applied to the captured word and XORed with {rcon, 24'h0} into `ks_out`, then → IDLE.
- `last_grant` updates on every accept.
- `st_out` and `ks_out` hold their value until overwritten by the next completed job of the same type. The `st_out` lanes update progressively during a job; they are meaningful only when `st_out_valid`=1.
- Request inputs are sampled only at accept; changes afterwards are ignored.

## Timing
- Reset (async assert, sync release): FSM = IDLE, `last_grant` = KEY, all outputs 0 (`st_out_valid`, `ks_out_valid`, `st_out`, `ks_out`, `busy`).
  - `st_ready` and `ks_ready` are combinational and evaluate to 1 in IDLE with no requests.
- State job: accept at edge E0; lanes 0–3 are written at E1–E4. `st_out_valid` is high in the cycle after E4, so latency is 4 cycles.
- Key job: accept at E0, result at E1. `ks_out_valid` is high in the cycle after E1, so latency is 1 cycle.
- FSM is in IDLE in the same cycle the out_valid pulses, so a new accept is possible there.
  - Back-to-back spacing: 5 cycles for state jobs, 2 cycles for key jobs.
- `busy` = 1 exactly in ST0–ST3 and KS.
- Reset asserted mid-job aborts immediately. No out_valid is produced for the aborted job, and partial `st_out` lanes are cleared.
- No output backpressure: the consumer must take the result on the valid pulse.

## Test plan
- State 00112233445566778899aabbccddeeff accepted alone → `st_out` = 638293c31bfc33f5c4eeacea4bc12816, `st_out_valid` 4 cycles after accept for exactly 1 cycle, `busy` high 4 cycles.
- Key 09cf4f3c, `ks_rot`=1, `ks_rcon`=01 → `ks_out` = 8b84eb01 one cycle after accept. Same word with `ks_rot`=0, `ks_rcon`=00 → 018a84eb.
- `RR_EN`=1, both valid continuously from reset → grants alternate state, key, state, key. Outputs match the per-type golden values; the other ready stays 0 during each job.
- `RR_EN`=0, both valid held → key accepted every 2 cycles, state never accepted; then drop `ks_valid` → state accepted at the next IDLE.
- Assert `rst` during ST2 → no `st_out_valid`, `st_out` = 0, FSM in IDLE; a new state job after release completes normally.
- Change `st_data` and `ks_word` every cycle after accept → results reflect only the accepted values.

Source files
------------

// File: rtl/aes_sbox_scheduler.sv
// Shared S-box scheduler: four S-boxes time-multiplexed between round SubBytes
// (four 32-bit lanes, one per cycle) and the key-expansion g-function.

module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  logic [7:0] sq;
  logic [7:0] inv;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), then the AES affine map
  always_comb begin
    sq  = din;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_sbox_scheduler #(
  parameter bit RR_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic [127:0] st_data,
  output logic         st_out_valid,
  output logic [127:0] st_out,
  input  logic         ks_valid,
  output logic         ks_ready,
  input  logic [31:0]  ks_word,
  input  logic         ks_rot,
  input  logic [7:0]   ks_rcon,
  output logic         ks_out_valid,
  output logic [31:0]  ks_out,
  output logic         busy
);
  localparam int unsigned STW = 128;
  localparam int unsigned WW  = 32;
  localparam int unsigned NSB = 4;
  localparam logic GRANT_ST  = 1'b0;
  localparam logic GRANT_KEY = 1'b1;

  typedef enum logic [2:0] {IDLE, ST0, ST1, ST2, ST3, KS} state_t;

  state_t           state, state_n;
  logic             last_grant;
  logic [STW-1:0]   st_buf;
  logic [WW-1:0]    ks_buf;
  logic [7:0]       rcon_buf;
  logic [WW-1:0]    sbox_in;
  logic [WW-1:0]    sbox_out;
  logic             st_acc;
  logic             ks_acc;

  for (genvar g = 0; g < NSB; g++) begin : g_sbox
    aes_sbox u_sbox (.din(sbox_in[8*g +: 8]), .dout(sbox_out[8*g +: 8]));
  end

  assign st_acc = st_valid & st_ready;
  assign ks_acc = ks_valid & ks_ready;

  // Next state, arbitration and S-box operand select
  always_comb begin
    state_n  = state;
    st_ready = 1'b0;
    ks_ready = 1'b0;
    sbox_in  = '0;
    case (state)
      IDLE: begin
        st_ready = 1'b1;
        ks_ready = 1'b1;
        if (st_valid && ks_valid) begin
          if (RR_EN && last_grant == GRANT_KEY) ks_ready = 1'b0;
          else                                  st_ready = 1'b0;
        end
        if (st_valid && st_ready)      state_n = ST0;
        else if (ks_valid && ks_ready) state_n = KS;
      end
      ST0: begin sbox_in = st_buf[31:0];   state_n = ST1;  end
      ST1: begin sbox_in = st_buf[63:32];  state_n = ST2;  end
      ST2: begin sbox_in = st_buf[95:64];  state_n = ST3;  end
      ST3: begin sbox_in = st_buf[127:96]; state_n = IDLE; end
      KS:  begin sbox_in = ks_buf;         state_n = IDLE; end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Request capture, grant history and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant   <= GRANT_KEY;
      st_buf       <= '0;
      ks_buf       <= '0;
      rcon_buf     <= '0;
      st_out       <= '0;
      ks_out       <= '0;
      st_out_valid <= 1'b0;
      ks_out_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      busy         <= (state_n != IDLE);
      st_out_valid <= (state == ST3);
      ks_out_valid <= (state == KS);
      if (st_acc) begin
        st_buf     <= st_data;
        last_grant <= GRANT_ST;
      end
      if (ks_acc) begin
        ks_buf     <= ks_rot ? {ks_word[23:0], ks_word[31:24]} : ks_word;
        rcon_buf   <= ks_rcon;
        last_grant <= GRANT_KEY;
      end
      case (state)
        ST0: st_out[31:0]   <= sbox_out;
        ST1: st_out[63:32]  <= sbox_out;
        ST2: st_out[95:64]  <= sbox_out;
        ST3: st_out[127:96] <= sbox_out;
        KS:  ks_out         <= sbox_out ^ {rcon_buf, 24'h0};
        default: ;
      endcase
    end
  end
endmodule
